// File: rtl/cpu_pkg.sv
// Shared CPU constants and types for the fetch stage.
//   XLEN       : datapath width
//   NOP_INSTR  : encoding written into a squashed IF/ID entry
//   PC_INCR    : sequential fetch step
//   ifid_t     : IF/ID register payload
//   align_word : force an address onto a word boundary
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_INCR   = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] instr;
    } ifid_t;

    // Masking keeps every input bit in use while clearing the byte offset.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage : cpu_pkg

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: pipeline control, instruction memory port, IF/ID
// payload and performance counters.
//   master : pipeline/memory side (drives stall, flush, redirect_pc, imem_instr)
//   slave  : fetch_stage side (drives imem_addr, ifid_*, perf_*)
interface fetch_stage_if;
    import cpu_pkg::*;

    logic            stall;
    logic            flush;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_instr;
    logic            ifid_valid;
    logic [XLEN-1:0] ifid_pc;
    logic [XLEN-1:0] ifid_pc_plus4;
    logic [XLEN-1:0] ifid_instr;
    logic [XLEN-1:0] perf_fetch_cnt;
    logic [XLEN-1:0] perf_stall_cnt;

    modport master (
        output stall, flush, redirect_pc, imem_instr,
        input  imem_addr, ifid_valid, ifid_pc, ifid_pc_plus4, ifid_instr,
               perf_fetch_cnt, perf_stall_cnt
    );

    modport slave (
        input  stall, flush, redirect_pc, imem_instr,
        output imem_addr, ifid_valid, ifid_pc, ifid_pc_plus4, ifid_instr,
               perf_fetch_cnt, perf_stall_cnt
    );

endinterface : fetch_stage_if

// File: rtl/fetch_stage_pc_register.sv
// Program counter with next-PC selection (redirect > hold > sequential).
//   clk, rst_n    : clock, async active-low reset (PC <= RESET_PC)
//   stall_i       : hold the PC
//   flush_i       : load the word-aligned redirect_pc_i (wins over stall_i)
//   redirect_pc_i : redirect target, low two bits ignored
//   pc_o          : current PC (register output)
module pc_register
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [XLEN-1:0] pc_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    // Next-PC mux; addition wraps naturally at 2^XLEN.
    always_comb begin
        pc_d = pc_q;
        if (flush_i) begin
            pc_d = align_word(redirect_pc_i);
        end else if (!stall_i) begin
            pc_d = pc_q + PC_INCR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule : pc_register

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, IF/ID pipeline register and optional
// performance counters.
//   clk, rst_n : clock, async active-low reset
//   bus        : fetch_stage_if.slave
//                in : stall, flush, redirect_pc, imem_instr
//                out: imem_addr (= PC), ifid_valid/pc/pc_plus4/instr,
//                     perf_fetch_cnt, perf_stall_cnt
// Build option: define FETCH_PERF_COUNTERS_EN to implement the counters;
// otherwise both counter outputs are tied to zero.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.slave  bus
);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4_c;

    pc_register #(
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (bus.stall),
        .flush_i       (bus.flush),
        .redirect_pc_i (bus.redirect_pc),
        .pc_o          (pc)
    );

    assign pc_plus4_c    = pc + PC_INCR;
    assign bus.imem_addr = pc;

    ifid_t ifid_q;
    ifid_t ifid_d;
    logic  valid_q;
    logic  valid_d;

    // IF/ID update: a flush squashes the entry but keeps its PC fields.
    always_comb begin
        ifid_d  = ifid_q;
        valid_d = valid_q;
        if (bus.flush) begin
            valid_d      = 1'b0;
            ifid_d.instr = NOP_INSTR;
        end else if (!bus.stall) begin
            valid_d         = 1'b1;
            ifid_d.pc       = pc;
            ifid_d.pc_plus4 = pc_plus4_c;
            ifid_d.instr    = bus.imem_instr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_q  <= '{pc: '0, pc_plus4: '0, instr: NOP_INSTR};
            valid_q <= 1'b0;
        end else begin
            ifid_q  <= ifid_d;
            valid_q <= valid_d;
        end
    end

    assign bus.ifid_valid    = valid_q;
    assign bus.ifid_pc       = ifid_q.pc;
    assign bus.ifid_pc_plus4 = ifid_q.pc_plus4;
    assign bus.ifid_instr    = ifid_q.instr;

`ifdef FETCH_PERF_COUNTERS_EN
    logic [XLEN-1:0] fetch_cnt_q;
    logic [XLEN-1:0] fetch_cnt_d;
    logic [XLEN-1:0] stall_cnt_q;
    logic [XLEN-1:0] stall_cnt_d;

    // Normal cycles and non-flushed stall cycles; both wrap.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (!bus.flush) begin
            if (bus.stall) begin
                stall_cnt_d = stall_cnt_q + XLEN'(1);
            end else begin
                fetch_cnt_d = fetch_cnt_q + XLEN'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.perf_fetch_cnt = fetch_cnt_q;
    assign bus.perf_stall_cnt = stall_cnt_q;
`else
    assign bus.perf_fetch_cnt = '0;
    assign bus.perf_stall_cnt = '0;
`endif

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// Randomized self-checking bench for fetch_stage against a cycle-level
// reference model of the fetch rules, plus directed corner cases.
module tb_fetch_stage;

    logic clk;
    logic rst_n;

    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 64-word instruction memory, index truncated from the address.
    logic [31:0] mem [64];
    assign bus.imem_instr = mem[bus.imem_addr[7:2]];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic [31:0] m_pc;
    logic [31:0] m_ifpc;
    logic [31:0] m_ifpc4;
    logic [31:0] m_instr;
    logic [31:0] m_valid;
    logic [31:0] m_fc;
    logic [31:0] m_sc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input logic [31:0] c);
`ifdef FETCH_PERF_COUNTERS_EN
        return c;
`else
        return (c & 32'h0);
`endif
    endfunction

    task automatic model_reset();
        m_pc    = 32'h0;
        m_ifpc  = 32'h0;
        m_ifpc4 = 32'h0;
        m_instr = 32'h0;
        m_valid = 32'h0;
        m_fc    = 32'h0;
        m_sc    = 32'h0;
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".imem_addr"},  bus.imem_addr,           m_pc);
        check_eq({tag, ".valid"},      32'(bus.ifid_valid),     m_valid);
        check_eq({tag, ".ifid_pc"},    bus.ifid_pc,             m_ifpc);
        check_eq({tag, ".ifid_pc4"},   bus.ifid_pc_plus4,       m_ifpc4);
        check_eq({tag, ".ifid_instr"}, bus.ifid_instr,          m_instr);
        check_eq({tag, ".fetch_cnt"},  bus.perf_fetch_cnt,      exp_cnt(m_fc));
        check_eq({tag, ".stall_cnt"},  bus.perf_stall_cnt,      exp_cnt(m_sc));
    endtask

    // Apply one cycle of control inputs, advance the model, check after the edge.
    task automatic step(input logic s, input logic f, input logic [31:0] r, input string tag);
        bus.stall       = s;
        bus.flush       = f;
        bus.redirect_pc = r;
        if (f) begin
            m_pc    = {r[31:2], 2'b00};
            m_valid = 32'h0;
            m_instr = 32'h0;
        end else if (!s) begin
            m_ifpc  = m_pc;
            m_ifpc4 = m_pc + 32'd4;
            m_instr = mem[m_pc[7:2]];
            m_valid = 32'h1;
            m_pc    = m_pc + 32'd4;
            m_fc    = m_fc + 32'd1;
        end else begin
            m_sc    = m_sc + 32'd1;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [31:0] sc_before;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h2008_0005;

        rst_n           = 1'b0;
        bus.stall       = 1'b0;
        bus.flush       = 1'b0;
        bus.redirect_pc = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");

        @(negedge clk);
        rst_n = 1'b1;

        // First fetch after reset release.
        step(1'b0, 1'b0, 32'h0, "first");
        check_eq("first.instr_word0", bus.ifid_instr, 32'h2008_0005);
        check_eq("first.addr4",       bus.imem_addr,  32'h4);

        // Reach PC=8, then stall three cycles.
        step(1'b0, 1'b0, 32'h0, "seq");
        sc_before = m_sc;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'h0, "stall");
            check_eq("stall.addr8", bus.imem_addr, 32'h8);
        end
        check_eq("stall.cnt_delta", bus.perf_stall_cnt - exp_cnt(sc_before), exp_cnt(32'd3));

        // Misaligned redirect.
        step(1'b0, 1'b1, 32'h0000_0043, "flush");
        check_eq("flush.addr40", bus.imem_addr, 32'h40);
        step(1'b0, 1'b0, 32'h0, "post_flush");
        check_eq("post_flush.ifid_pc", bus.ifid_pc, 32'h40);

        // Flush beats stall.
        step(1'b1, 1'b1, 32'h0000_0100, "flush_stall");
        check_eq("flush_stall.addr", bus.imem_addr, 32'h100);

        // PC wrap at the top of the address space.
        step(1'b0, 1'b1, 32'hFFFF_FFFC, "to_top");
        step(1'b0, 1'b0, 32'h0, "wrap");
        check_eq("wrap.addr0", bus.imem_addr,     32'h0);
        check_eq("wrap.pc4_0", bus.ifid_pc_plus4, 32'h0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), $urandom, "rand");
        end

        // Asynchronous reset mid-cycle during a flush.
        bus.flush       = 1'b1;
        bus.redirect_pc = 32'h0000_0200;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_hold");
        bus.flush = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 32'h0, "after_rst");
        check_eq("after_rst.instr", bus.ifid_instr, 32'h2008_0005);

        for (int i = 0; i < 100; i++) begin
            step(($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0), $urandom, "rand2");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_fetch_stage

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded while reset is asserted.
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port rst_n, input, 1, an asynchronous active-low reset.
REQ-004 The block SHALL have port stall, input, 1, a downstream hold request that freezes the PC and the IF/ID register.
REQ-005 The block SHALL have port flush, input, 1, which redirects fetch to redirect_pc and squashes the IF/ID entry.
REQ-006 The block SHALL have port redirect_pc, input, 32, the branch/jump target, sampled only when flush=1.
REQ-007 The block SHALL have port imem_addr, output, 32, which drives the instruction-memory address.
REQ-008 The block SHALL have port imem_instr, input, 32, the combinational instruction-memory read data.
REQ-009 The block SHALL have port ifid_valid, output, 1, which marks the IF/ID entry as a real instruction.
REQ-010 The block SHALL have ports ifid_pc, ifid_pc_plus4 and ifid_instr, each output, 32, holding the registered fetch PC, PC+4 and instruction.
REQ-011 The block SHALL have ports perf_fetch_cnt and perf_stall_cnt, each output, 32, which are performance counters (see Configuration).

Function
REQ-012 imem_addr SHALL equal the PC register combinationally, with zero-cycle latency to imem_instr.
REQ-013 Normal cycle (stall=0, flush=0): on the clock edge, PC<=PC+4; ifid_pc<=PC; ifid_pc_plus4<=PC+4; ifid_instr<=imem_instr; ifid_valid<=1.
REQ-014 Stall cycle (stall=1, flush=0): the PC and all ifid_* registers SHALL hold their values.
REQ-015 Flush cycle (flush=1): PC<={redirect_pc[31:2],2'b00}; ifid_valid<=0; ifid_instr<=NOP_INSTR; ifid_pc and ifid_pc_plus4 SHALL hold their values.
REQ-016 flush SHALL take priority over stall when both are 1 in the same cycle.
REQ-017 PC addition SHALL be modulo 2^32, so 32'hFFFF_FFFC+4 wraps to 32'h0000_0000 with no error indication.
REQ-018 The block SHALL perform no range check; addresses beyond memory depth are resolved by the memory's own index truncation.
REQ-019 redirect_pc bits [1:0] SHALL be ignored, and the PC SHALL always be word-aligned.
REQ-020 Instruction latency SHALL be one cycle, from the PC presented on imem_addr to the corresponding ifid_* outputs.

Reset
REQ-021 While rst_n=0, asynchronously: PC=RESET_PC; ifid_valid=0; ifid_pc=0; ifid_pc_plus4=0; ifid_instr=NOP_INSTR; both counters=0.
REQ-022 Reset asserted mid-stall or mid-flush SHALL override both, and no partial update SHALL survive.
REQ-023 The first edge after rst_n deasserts SHALL capture the instruction at RESET_PC with ifid_valid=1, provided stall=0 and flush=0.

Configuration
REQ-024 Macro FETCH_PERF_COUNTERS_EN, when defined, SHALL implement the two counters.
- perf_fetch_cnt increments on every normal cycle.
- perf_stall_cnt increments on every stall cycle without flush.
- Both wrap modulo 2^32.
REQ-025 Without FETCH_PERF_COUNTERS_EN, both counter ports SHALL exist and be tied to 32'h0, with no counter flops.

Structure
REQ-026 Package cpu_pkg SHALL hold XLEN=32, NOP_INSTR=32'h0000_0000 and the PC increment constant 4.
REQ-027 The PC register with next-PC mux SHALL be one sub-module, pc_register; the IF/ID register and counters SHALL live in fetch_stage.

Verification
REQ-028 Reset release with RESET_PC=0 and memory word0=32'h2008_0005 -> after edge 1: ifid_pc=0, ifid_instr=32'h2008_0005, ifid_valid=1, imem_addr=4.
REQ-029 stall=1 for 3 cycles at PC=8 -> imem_addr stays 8 and ifid_* are unchanged; with the macro defined, perf_stall_cnt advances by 3.
REQ-030 flush=1 with redirect_pc=32'h0000_0043 -> next cycle: imem_addr=32'h40, ifid_valid=0, ifid_instr=0; the following cycle: ifid_pc=32'h40.
REQ-031 flush=1 and stall=1 together with redirect_pc=32'h100 -> PC=32'h100 and ifid_valid=0, i.e. flush wins.
REQ-032 PC=32'hFFFF_FFFC with a normal cycle -> imem_addr=0 and ifid_pc_plus4=0.
REQ-033 rst_n pulsed low mid-cycle during flush -> immediate PC=RESET_PC and ifid_valid=0 without waiting for a clock edge; without the macro, both counters read 0 throughout.
